wptr_ctrl: RTL

- Write-domain pointer controller for the ASYNC_FIFO; it sits upstream of the read-pointer logic and feeds it.
- Accepts write requests and gates the memory write enable. Advances a binary/Gray write pointer and publishes the Gray pointer for synchronisation into the read domain.
- Produces registered full, almost-full, occupancy and sticky-overflow status from the read pointer after it has been synchronised back into the write domain.

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/b2g_conv.sv | 11 +
 rtl/g2b_conv.sv | 16 +
 rtl/wptr_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO slice.
package async_fifo_pkg;

  localparam int MAX_W = 32;

  // FIFO depth for a given address width.
  function automatic int depth(input int ptr_width);
    return 1 << ptr_width;
  endfunction

  // Binary to Gray, zero-extended operands up to MAX_W bits.
  function automatic logic [MAX_W-1:0] b2g(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary, prefix XOR from the MSB down.
  function automatic logic [MAX_W-1:0] g2b(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/b2g_conv.sv
// Combinational binary-to-Gray converter.
module b2g_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/g2b_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module g2b_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each bit is an independent reduction, so no bit depends on another
  // output bit and the network stays a flat XOR tree.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer controller for the asynchronous FIFO: gates the memory
// write strobe, advances the binary/Gray write pointer and derives full,
// almost-full, occupancy and sticky-overflow status from the synchronised
// read pointer.
module wptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = 3,
  parameter int AFULL_LVL = 6
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [PTR_WIDTH:0]   wq2_rptr,
  input  logic                 wovf_clr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [PTR_WIDTH:0]   wcount,
  output logic                 wovf
);

  localparam int W     = PTR_WIDTH + 1;
  localparam int DEPTH = depth(PTR_WIDTH);
  // Threshold clamped to the FIFO depth so an out-of-range setting behaves
  // like "almost full only when full".
  localparam logic [W-1:0] AFULL_THR =
    (AFULL_LVL > DEPTH) ? W'(DEPTH) : W'(AFULL_LVL);

  logic [W-1:0] wbin;
  logic [W-1:0] wbin_next;
  logic [W-1:0] wgray_next;
  logic [W-1:0] rbin_sync;
  logic [W-1:0] occ_next;
  logic [W-1:0] full_gray;

  // A write is accepted only while not full; this same term advances wbin.
  assign wen       = winc & ~wfull;
  assign wbin_next = wbin + W'(wen);
  assign waddr     = wbin[PTR_WIDTH-1:0];

  b2g_conv #(.WIDTH(W)) u_b2g (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  g2b_conv #(.WIDTH(W)) u_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_sync)
  );

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that is the top two bits inverted.
  assign full_gray = {~wq2_rptr[W-1:W-2], wq2_rptr[W-3:0]};
  assign occ_next  = wbin_next - rbin_sync;

  // Pointer and status registers, all cleared asynchronously.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so wfull and wbin here see the same old state that wen was built from.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (occ_next >= AFULL_THR);
      wcount       <= occ_next;
    end
  end

  // Sticky overflow: a refused write sets it, and set wins over clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)             wovf <= 1'b0;
    else if (winc && wfull)  wovf <= 1'b1;
    else if (wovf_clr)       wovf <= 1'b0;
  end

endmodule
